// File: rtl/dmem_ctrl.sv
// Data-DRAM front end: serves MEM-stage loads/stores and a debug word port,
// splitting sub-word stores into a registered read-modify-write.
module dmem_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_misalign,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_valid,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_a,
  output logic [31:0]       mem_d,
  input  logic [31:0]       mem_q
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [31:0]       merge_q, merge_d;
  logic [WA_W-1:0]   wa_q, wa_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic              misalign_q, misalign_d;

  logic              mem_we_c, stall_c, gnt_c;
  logic [WA_W-1:0]   mem_a_c;
  logic [31:0]       mem_d_c;
  logic [WA_W-1:0]   cpu_wa, dbg_wa;
  logic              sub_word, cpu_misal, starved;
  logic              unused_addr_bits;

  assign cpu_wa   = cpu_addr[ADDR_W-1:2];
  assign dbg_wa   = dbg_addr[ADDR_W-1:2];
  assign sub_word = ~cpu_size[1];
  assign cpu_misal = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                     (cpu_size[1] && (cpu_addr[1:0] != 2'b00));
  assign starved  = (starve_q == CNT_W'(STARVE_MAX));
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W], dbg_addr[1:0]};

  // Replace one byte or half-word lane of the old word with right-aligned store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic        is_half,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = old_w;
    if (is_half) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    merge_d     = merge_q;
    wa_d        = wa_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_valid_d = 1'b0;
    misalign_d  = 1'b0;
    mem_we_c    = 1'b0;
    mem_a_c     = cpu_wa;
    mem_d_c     = cpu_wdata;
    stall_c     = 1'b0;
    gnt_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (dbg_req && (!cpu_req || starved)) begin
          gnt_c    = 1'b1;
          stall_c  = cpu_req;
          mem_a_c  = dbg_wa;
          mem_we_c = dbg_we;
          mem_d_c  = dbg_wdata;
          if (!dbg_we) begin
            dbg_rdata_d = mem_q;
            dbg_valid_d = 1'b1;
          end
        end else if (cpu_req && cpu_we) begin
          if (cpu_misal) begin
            misalign_d = 1'b1;
          end else if (sub_word) begin
            stall_c = 1'b1;
            merge_d = merge_lane(mem_q, cpu_wdata, cpu_size[0], cpu_addr[1:0]);
            wa_d    = cpu_wa;
            state_d = RMW_WR;
          end else begin
            mem_we_c = 1'b1;
          end
        end
      end
      RMW_WR: begin
        // Only registered state drives the write; live CPU inputs are ignored.
        mem_we_c = 1'b1;
        mem_a_c  = wa_q;
        mem_d_c  = merge_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!dbg_req || gnt_c) starve_d = '0;
    else if (!starved)     starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      merge_q     <= '0;
      wa_q        <= '0;
      dbg_rdata_q <= '0;
      dbg_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      merge_q     <= merge_d;
      wa_q        <= wa_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_valid_q <= dbg_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  // Strobes are held low while reset is asserted so an in-flight write is abandoned.
  assign mem_we       = mem_we_c & rst_n;
  assign cpu_stall    = stall_c & rst_n;
  assign dbg_gnt      = gnt_c & rst_n;
  assign mem_a        = mem_a_c;
  assign mem_d        = mem_d_c;
  assign cpu_rdata    = mem_q;
  assign cpu_misalign = misalign_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign dbg_valid    = dbg_valid_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural DRAM and a word-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned NWORDS     = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_stall, cpu_misalign;
  logic              dbg_req, dbg_we;
  logic [31:0]       dbg_addr, dbg_wdata, dbg_rdata;
  logic              dbg_gnt, dbg_valid;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_a;
  logic [31:0]       mem_d, mem_q;

  logic              bd_we = 1'b0;
  logic [ADDR_W-3:0] bd_a = '0;
  logic [31:0]       bd_d = '0;
  logic [31:0]       dram    [NWORDS];
  logic [31:0]       ref_mem [NWORDS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cpu_misalign(cpu_misalign),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  // Single-port DRAM: synchronous write, asynchronous read; backdoor port for preloads.
  always @(posedge clk) begin
    if (bd_we)       dram[bd_a]  <= bd_d;
    else if (mem_we) dram[mem_a] <= mem_d;
  end
  assign mem_q = dram[mem_a];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    bd_we = 1; bd_a = (ADDR_W-2)'(idx); bd_d = val;
    tick();
    bd_we = 0;
    ref_mem[idx] = val;
  endtask

  // Expected word after a sub-word store: plain mask-and-shift arithmetic on the reference.
  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] off);
    int unsigned sh;
    logic [31:0] mask;
    mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = (size == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
    return (old_w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    set_cpu(1, 1, 2'b10, 32'h10, 32'h1234_5678);
    dbg_req = 1;
    #3;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    n_checks++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", dbg_gnt); end
    n_checks++; if (dbg_valid !== 1'b0 || dbg_rdata !== 32'h0 || cpu_misalign !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got valid=%b rdata=%h mis=%b exp 0/0/0", dbg_valid, dbg_rdata, cpu_misalign);
    end
    tick();
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_word_store_load();
    set_cpu(1, 1, 2'b10, 32'h010, 32'hDEAD_BEEF);
    #2;
    n_checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL sw_strobe got we=%b stall=%b exp we=1 stall=0", mem_we, cpu_stall);
    end
    n_checks++; if (mem_a !== 8'h04 || mem_d !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_addr_data got a=%h d=%h exp a=04 d=deadbeef", mem_a, mem_d);
    end
    tick();
    ref_mem[4] = 32'hDEAD_BEEF;
    set_cpu(1, 0, 2'b10, 32'h010, 32'h0);
    #2;
    n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_same_cycle got rdata=%h stall=%b we=%b exp deadbeef/0/0", cpu_rdata, cpu_stall, mem_we);
    end
    tick();
    idle_inputs();
    #2;
    n_checks++; if (mem_we !== 1'b0 || mem_a !== 8'h00) begin
      n_fail++; $display("FAIL idle_cycle got we=%b a=%h exp we=0 a=00", mem_we, mem_a);
    end
    tick();
  endtask

  task automatic test_byte_store();
    logic [1:0]  lanes [4];
    logic [7:0]  vals  [4];
    logic [31:0] exp_w;
    lanes[0] = 2'd2; lanes[1] = 2'd0; lanes[2] = 2'd1; lanes[3] = 2'd3;
    vals[0]  = 8'hAB; vals[1] = 8'h5A; vals[2] = 8'hC3; vals[3] = 8'h7E;
    for (int i = 0; i < 4; i++) begin
      preload(8, 32'h1122_3344);
      exp_w = ref_merge(32'h1122_3344, {24'hFFFFFF, vals[i]}, 2'b00, lanes[i]);
      set_cpu(1, 1, 2'b00, 32'h020 | 32'(lanes[i]), {24'hFFFFFF, vals[i]});
      #2;
      n_checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL sb_cycle1 lane%0d got stall=%b we=%b exp stall=1 we=0", lanes[i], cpu_stall, mem_we);
      end
      tick();
      #2;
      n_checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_a !== 8'h08 || mem_d !== exp_w) begin
        n_fail++; $display("FAIL sb_cycle2 lane%0d got stall=%b we=%b a=%h d=%h exp 0/1/08/%h",
                           lanes[i], cpu_stall, mem_we, mem_a, mem_d, exp_w);
      end
      tick();
      ref_mem[8] = exp_w;
      idle_inputs();
      tick();
      n_checks++; if (dram[8] !== ref_mem[8]) begin
        n_fail++; $display("FAIL sb_result lane%0d got=%h exp=%h", lanes[i], dram[8], ref_mem[8]);
      end
    end
  endtask

  task automatic test_half_store();
    preload(9, 32'h1122_3344);
    set_cpu(1, 1, 2'b01, 32'h026, 32'h0000_CAFE);
    #2;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL sh_stall got=%b exp=1", cpu_stall); end
    tick();
    tick();
    idle_inputs();
    ref_mem[9] = 32'hCAFE_3344;
    #1;
    n_checks++; if (dram[9] !== 32'hCAFE_3344) begin n_fail++; $display("FAIL sh_upper got=%h exp=cafe3344", dram[9]); end
    set_cpu(1, 1, 2'b01, 32'h025, 32'h0000_BEEF);
    #2;
    n_checks++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL sh_misal_strobe got we=%b stall=%b exp 0/0", mem_we, cpu_stall);
    end
    tick();
    idle_inputs();
    n_checks++; if (cpu_misalign !== 1'b1) begin n_fail++; $display("FAIL sh_misal_pulse got=%b exp=1", cpu_misalign); end
    tick();
    n_checks++; if (cpu_misalign !== 1'b0 || dram[9] !== 32'hCAFE_3344) begin
      n_fail++; $display("FAIL sh_misal_after got mis=%b word=%h exp 0/cafe3344", cpu_misalign, dram[9]);
    end
  endtask

  task automatic test_starvation();
    logic granted;
    logic prev_gnt;
    granted  = 0;
    prev_gnt = 0;
    for (int c = 1; c <= 10; c++) begin
      set_cpu(1, 0, 2'b10, 32'h010, 32'h0);
      dbg_req = !granted; dbg_we = 0; dbg_addr = 32'h020;
      #2;
      n_checks++; if (dbg_gnt !== (c == 5) || cpu_stall !== (c == 5)) begin
        n_fail++; $display("FAIL starve_cycle%0d got gnt=%b stall=%b exp %b/%b", c, dbg_gnt, cpu_stall, c == 5, c == 5);
      end
      n_checks++; if (dbg_valid !== prev_gnt) begin
        n_fail++; $display("FAIL starve_valid%0d got=%b exp=%b", c, dbg_valid, prev_gnt);
      end
      if (prev_gnt) begin
        n_checks++; if (dbg_rdata !== ref_mem[8]) begin
          n_fail++; $display("FAIL starve_rdata got=%h exp=%h", dbg_rdata, ref_mem[8]);
        end
      end
      prev_gnt = dbg_gnt;
      if (dbg_gnt) granted = 1;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_rmw_vs_dbg();
    logic [31:0] exp_w;
    logic [31:0] exp2;
    // Grant on the first cycle with the CPU quiet after RMW completes.
    preload(12, 32'hA5A5_5A5A);
    exp_w = ref_merge(32'hA5A5_5A5A, 32'h0000_0099, 2'b00, 2'd1);
    set_cpu(1, 1, 2'b00, 32'h031, 32'h99);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h030;
    #2;
    n_checks++; if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL rmwdbg_c1 got gnt=%b stall=%b exp 0/1", dbg_gnt, cpu_stall);
    end
    tick();
    #2;
    n_checks++; if (dbg_gnt !== 1'b0 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rmwdbg_c2 got gnt=%b we=%b exp 0/1", dbg_gnt, mem_we);
    end
    tick();
    ref_mem[12] = exp_w;
    cpu_req = 0;
    #2;
    n_checks++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL rmwdbg_c3 got gnt=%b exp=1", dbg_gnt); end
    tick();
    dbg_req = 0;
    n_checks++; if (dbg_valid !== 1'b1 || dbg_rdata !== exp_w) begin
      n_fail++; $display("FAIL rmwdbg_read got valid=%b rdata=%h exp 1/%h", dbg_valid, dbg_rdata, exp_w);
    end
    tick();
    // CPU stays busy: grant only once the wait count saturates (RMW cycle counts too).
    exp2 = ref_merge(exp_w, 32'h0000_1234, 2'b01, 2'd0);
    set_cpu(1, 1, 2'b01, 32'h030, 32'h1234);
    dbg_req = 1; dbg_addr = 32'h030;
    for (int c = 1; c <= 5; c++) begin
      #2;
      n_checks++; if (dbg_gnt !== (c == 5)) begin
        n_fail++; $display("FAIL rmwdbg_starve%0d got gnt=%b exp=%b", c, dbg_gnt, c == 5);
      end
      tick();
      if (c == 2) begin
        ref_mem[12] = exp2;
        set_cpu(1, 0, 2'b10, 32'h010, 32'h0);
      end
    end
    dbg_req = 0;
    n_checks++; if (dbg_rdata !== exp2 || dram[12] !== exp2) begin
      n_fail++; $display("FAIL rmwdbg_result got rdata=%h word=%h exp %h", dbg_rdata, dram[12], exp2);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    preload(20, 32'h0F0F_0F0F);
    set_cpu(1, 1, 2'b00, 32'h050, 32'hEE);
    tick();
    #1;
    rst_n = 0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstrmw_we got=%b exp=0", mem_we); end
    tick();
    idle_inputs();
    rst_n = 1;
    #1;
    n_checks++; if (dram[20] !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL rstrmw_word got=%h exp=0f0f0f0f", dram[20]);
    end
    n_checks++; if (dbg_valid !== 1'b0 || dbg_rdata !== 32'h0 || cpu_misalign !== 1'b0) begin
      n_fail++; $display("FAIL rstrmw_regs got valid=%b rdata=%h mis=%b exp 0", dbg_valid, dbg_rdata, cpu_misalign);
    end
    set_cpu(1, 0, 2'b10, 32'h010, 32'h0);
    #2;
    n_checks++; if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_a !== 8'h04) begin
      n_fail++; $display("FAIL rstrmw_idle got stall=%b we=%b a=%h exp 0/0/04", cpu_stall, mem_we, mem_a);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random_cpu();
    int unsigned idx, op;
    logic [1:0]  off, size;
    logic [31:0] addr, wd, exp_w;
    logic        mis;
    for (int i = 0; i < 16; i++) preload(32 + i, $urandom);
    for (int t = 0; t < 200; t++) begin
      op   = $urandom_range(0, 3);
      idx  = 32 + $urandom_range(0, 15);
      off  = 2'($urandom_range(0, 3));
      addr = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2) | 32'(off);
      wd   = $urandom;
      size = (op == 2) ? 2'b00 : (op == 3) ? 2'b01 : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10);
      set_cpu(1, op != 0, size, addr, wd);
      #2;
      if (op == 0) begin
        n_checks++; if (cpu_rdata !== ref_mem[idx] || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL rnd_load t=%0d got rdata=%h stall=%b we=%b exp %h/0/0", t, cpu_rdata, cpu_stall, mem_we, ref_mem[idx]);
        end
        tick();
        continue;
      end
      mis = (op == 3) ? off[0] : (op == 1) ? (off != 2'b00) : 1'b0;
      if (mis) begin
        n_checks++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
          n_fail++; $display("FAIL rnd_misal t=%0d got we=%b stall=%b exp 0/0", t, mem_we, cpu_stall);
        end
        tick();
        idle_inputs();
        n_checks++; if (cpu_misalign !== 1'b1) begin
          n_fail++; $display("FAIL rnd_misal_pulse t=%0d got=%b exp=1", t, cpu_misalign);
        end
      end else if (op == 1) begin
        n_checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0 || mem_d !== wd) begin
          n_fail++; $display("FAIL rnd_sw t=%0d got we=%b stall=%b d=%h exp 1/0/%h", t, mem_we, cpu_stall, mem_d, wd);
        end
        tick();
        ref_mem[idx] = wd;
      end else begin
        exp_w = ref_merge(ref_mem[idx], wd, size, off);
        n_checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL rnd_rmw1 t=%0d got stall=%b we=%b exp 1/0", t, cpu_stall, mem_we);
        end
        tick();
        set_cpu($urandom_range(0, 1) == 1, 1, 2'($urandom_range(0, 3)), $urandom, $urandom);
        #2;
        n_checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b0 || mem_a !== 8'(idx) || mem_d !== exp_w) begin
          n_fail++; $display("FAIL rnd_rmw2 t=%0d got we=%b stall=%b a=%h d=%h exp 1/0/%h/%h",
                             t, mem_we, cpu_stall, mem_a, mem_d, 8'(idx), exp_w);
        end
        tick();
        ref_mem[idx] = exp_w;
      end
      idle_inputs();
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      set_cpu(1, 0, 2'b10, 32'(32 + i) << 2, 32'h0);
      #2;
      n_checks++; if (cpu_rdata !== ref_mem[32 + i]) begin
        n_fail++; $display("FAIL rnd_final w%0d got=%h exp=%h", 32 + i, cpu_rdata, ref_mem[32 + i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random_arb();
    int unsigned waited;
    int unsigned didx;
    logic        exp_gnt, prev_rd;
    logic [31:0] prev_word;
    waited  = 0;
    prev_rd = 0;
    prev_word = 0;
    didx = 32;
    for (int c = 0; c < 80; c++) begin
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1; dbg_we = 0; didx = 32 + $urandom_range(0, 15);
        dbg_addr = 32'(didx) << 2; waited = 0;
      end
      set_cpu($urandom_range(0, 3) != 0, 0, 2'b10, 32'($urandom_range(32, 47)) << 2, 32'h0);
      exp_gnt = dbg_req && (!cpu_req || waited >= STARVE_MAX);
      #2;
      n_checks++; if (dbg_gnt !== exp_gnt || cpu_stall !== (exp_gnt && cpu_req)) begin
        n_fail++; $display("FAIL arb_c%0d got gnt=%b stall=%b exp %b/%b", c, dbg_gnt, cpu_stall, exp_gnt, exp_gnt && cpu_req);
      end
      n_checks++; if (dbg_valid !== prev_rd || (prev_rd && dbg_rdata !== prev_word)) begin
        n_fail++; $display("FAIL arb_rd%0d got valid=%b rdata=%h exp %b/%h", c, dbg_valid, dbg_rdata, prev_rd, prev_word);
      end
      prev_rd   = exp_gnt;
      prev_word = ref_mem[didx];
      tick();
      if (exp_gnt) dbg_req = 0;
      else if (dbg_req && waited < STARVE_MAX) waited++;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_half_store();
    test_starvation();
    test_rmw_vs_dbg();
    test_reset_mid_rmw();
    test_random_cpu();
    test_random_arb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
